upsampler: RTL and testbench
============================

UPSAMPLER -- requirements
Module: upsampler

Interface
REQ-001 Parameter DATA_WIDTH_INP, default 8, sample width in bits (signed two's complement).
REQ-002 Parameter CIC_R, default 4, interpolation ratio, legal range >= 2.
REQ-003 Parameter HOLD_MODE, default 0; 0 = zero-stuff, 1 = sample-and-hold.
REQ-004 Parameter FIFO_DEPTH, default 2, input buffer entries, power of two >= 2.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-007 clear  input  1  synchronous clear, same effect as reset, priority over all other inputs.
REQ-008 inp_samp_data  input  DATA_WIDTH_INP  low-rate input sample, signed.
REQ-009 inp_samp_str  input  1  input sample strobe, one-cycle pulse per sample.
REQ-010 out_tick  input  1  high-rate output slot strobe from downstream, one-cycle pulse.
REQ-011 out_samp_data  output  DATA_WIDTH_INP  high-rate output sample, signed, registered.
REQ-012 out_samp_str  output  1  output sample strobe, registered.
REQ-013 overflow  output  1  sticky, input sample dropped.
REQ-014 underflow  output  1  sticky, output slot found buffer empty at phase 0.
REQ-015 fifo_level  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-016 Input buffer SHALL be a FIFO_DEPTH-entry FIFO written on inp_samp_str, read only on out_tick with phase == 0.
REQ-017 Phase counter, width $clog2(CIC_R), SHALL advance on every out_tick: phase == CIC_R-1 wraps to 0, else phase+1.
REQ-018 Every out_tick at cycle t SHALL produce out_samp_str = 1 at t+1; out_samp_str SHALL be 0 at t+1 if no out_tick at t.
REQ-019 out_tick with phase 0 and buffer non-empty: pop head, out_samp_data = popped sample, stored as held value.
REQ-020 out_tick with phase 1..CIC_R-1: out_samp_data = 0 when HOLD_MODE = 0, held value when HOLD_MODE = 1.
REQ-021 out_tick with phase 0 and buffer empty: out_samp_data = 0, underflow set, phase SHALL stay 0, held value unchanged.
REQ-022 out_samp_data SHALL keep its value in cycles without out_tick.
REQ-023 No write-to-read bypass: sample written at cycle t is first readable by out_tick at t+1; same-cycle write into empty buffer plus phase-0 out_tick = underflow, written sample retained.
REQ-024 inp_samp_str with buffer full and no pop that cycle: sample dropped, contents unchanged, overflow set.
REQ-025 inp_samp_str with buffer full and simultaneous pop: write accepted, level unchanged, no overflow.
REQ-026 fifo_level SHALL be +1 on write-only, -1 on pop-only, unchanged on both or neither; never exceeds FIFO_DEPTH.
REQ-027 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 overflow and underflow SHALL remain 1 until reset or clear.
REQ-029 No arithmetic on data path; output width equals input width, no gain or scaling.

Reset
REQ-030 On reset_n low (asynchronous) or clear high (synchronous): out_samp_data = 0, out_samp_str = 0, overflow = 0, underflow = 0, fifo_level = 0, phase = 0, held value = 0, pointers = 0.
REQ-031 Reset or clear mid-burst SHALL discard buffered samples; first out_tick after release is phase 0.
REQ-032 clear asserted with out_tick or inp_samp_str SHALL ignore both in that cycle.

Verification (CIC_R = 4, DATA_WIDTH_INP = 8, FIFO_DEPTH = 2)
REQ-033 HOLD_MODE 0: write 0x05, then 4 out_ticks -> out_samp_data 0x05, 0x00, 0x00, 0x00, each strobe one cycle after its tick, underflow = 0.
REQ-034 HOLD_MODE 1: write -3 (0xFD), then 8 ticks with write 0x10 between tick 2 and 3 -> 0xFD x4, then 0x10 x4.
REQ-035 Empty buffer, 2 ticks -> two strobes with data 0x00, underflow = 1, phase still 0; write 0x22, next tick -> 0x22.
REQ-036 Write 0x01, 0x02, 0x03 with no ticks -> fifo_level = 2, overflow = 1; 8 ticks yield 0x01 then 0x02 at phase 0.
REQ-037 Buffer full, inp_samp_str concurrent with phase-0 tick -> level stays 2, overflow stays 0.
REQ-038 Write 0x7F, 2 ticks, pulse clear, then 1 tick -> outputs cleared, fifo_level = 0, tick gives 0x00 with underflow = 1.

Source files
------------

// File: rtl/upsampler.sv
// Interpolating upsampler front end: buffers low-rate samples in a small FIFO and
// emits one sample per CIC_R output slots, zero-stuffed or held between them.
module upsampler #(
    parameter int DATA_WIDTH_INP = 8,
    parameter int CIC_R          = 4,
    parameter int HOLD_MODE      = 0,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic [DATA_WIDTH_INP-1:0]       inp_samp_data,
    input  logic                            inp_samp_str,
    input  logic                            out_tick,
    output logic [DATA_WIDTH_INP-1:0]       out_samp_data,
    output logic                            out_samp_str,
    output logic                            overflow,
    output logic                            underflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int DW = DATA_WIDTH_INP;
    localparam int PW = (CIC_R > 1) ? $clog2(CIC_R) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [DW-1:0] held_q, held_d;
    logic [DW-1:0] data_q, data_d;
    logic          str_q, str_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          empty, full, phase_zero, pop, push;
    logic [DW-1:0] head;
    logic [PW-1:0] phase_next;

    always_comb begin
        empty      = (level_q == '0);
        full       = (level_q == LW'(FIFO_DEPTH));
        phase_zero = (phase_q == '0);
        head       = mem_q[rd_ptr_q];
        phase_next = (phase_q == PW'(CIC_R - 1)) ? '0 : phase_q + PW'(1);
        // A same-cycle write never feeds the read: pop depends only on registered level.
        pop        = !clear && out_tick && phase_zero && !empty;
        push       = !clear && inp_samp_str && (!full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        phase_d  = phase_q;
        held_d   = held_q;
        data_d   = data_q;
        str_d    = out_tick;
        ovf_d    = ovf_q | (inp_samp_str && full && !pop);
        udf_d    = udf_q | (out_tick && phase_zero && empty);

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (out_tick) begin
            if (phase_zero) begin
                if (!empty) begin
                    data_d  = head;
                    held_d  = head;
                    phase_d = phase_next;
                end else begin
                    data_d  = '0;
                end
            end else begin
                data_d  = (HOLD_MODE != 0) ? held_q : '0;
                phase_d = phase_next;
            end
        end

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            phase_d  = '0;
            held_d   = '0;
            data_d   = '0;
            str_d    = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            phase_q  <= '0;
            held_q   <= '0;
            data_q   <= '0;
            str_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
            held_q   <= held_d;
            data_q   <= data_d;
            str_q    <= str_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage needs no reset: entries are only read while the level says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= inp_samp_data;
    end

    assign out_samp_data = data_q;
    assign out_samp_str  = str_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_upsampler.sv
// Directed bench: a zero-stuff and a sample-and-hold instance share all inputs
// and are checked against hand-computed sequences.
module tb_upsampler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] inp_samp_data = '0;
    logic       inp_samp_str = 1'b0;
    logic       out_tick = 1'b0;

    logic [7:0] zs_data, hd_data;
    logic       zs_str, hd_str, zs_ovf, hd_ovf, zs_udf, hd_udf;
    logic [1:0] zs_lvl, hd_lvl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    upsampler #(.DATA_WIDTH_INP(8), .CIC_R(4), .HOLD_MODE(0), .FIFO_DEPTH(2)) u_zs (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .inp_samp_data(inp_samp_data), .inp_samp_str(inp_samp_str), .out_tick(out_tick),
        .out_samp_data(zs_data), .out_samp_str(zs_str),
        .overflow(zs_ovf), .underflow(zs_udf), .fifo_level(zs_lvl)
    );

    upsampler #(.DATA_WIDTH_INP(8), .CIC_R(4), .HOLD_MODE(1), .FIFO_DEPTH(2)) u_hd (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .inp_samp_data(inp_samp_data), .inp_samp_str(inp_samp_str), .out_tick(out_tick),
        .out_samp_data(hd_data), .out_samp_str(hd_str),
        .overflow(hd_ovf), .underflow(hd_udf), .fifo_level(hd_lvl)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear = 1'b0; inp_samp_str = 1'b0; out_tick = 1'b0; inp_samp_data = '0;
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic write(input logic [7:0] d);
        inp_samp_data = d; inp_samp_str = 1'b1;
        cyc();
        inp_samp_str = 1'b0;
    endtask

    task automatic tick();
        out_tick = 1'b1;
        cyc();
        out_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if ({zs_data, hd_data} !== 16'h0) begin fails++; $display("FAIL reset_data got %h/%h want 00/00", zs_data, hd_data); end
        tests++; if ({zs_str, hd_str, zs_ovf, hd_ovf, zs_udf, hd_udf} !== 6'b0) begin fails++; $display("FAIL reset_flags got %b%b%b%b%b%b want 000000", zs_str, hd_str, zs_ovf, hd_ovf, zs_udf, hd_udf); end
        tests++; if ({zs_lvl, hd_lvl} !== 4'b0) begin fails++; $display("FAIL reset_level got %0d/%0d want 0/0", zs_lvl, hd_lvl); end
        // asynchronous assertion between clock edges
        write(8'h44);
        tick();
        #2 reset_n = 1'b0;
        #1;
        tests++; if ({zs_data, hd_data, zs_str, hd_str} !== 18'h0) begin fails++; $display("FAIL async_reset got data %h/%h str %b/%b want 0", zs_data, hd_data, zs_str, hd_str); end
        tests++; if ({zs_lvl, hd_lvl} !== 4'b0) begin fails++; $display("FAIL async_reset_level got %0d/%0d want 0/0", zs_lvl, hd_lvl); end
        do_reset();
    endtask

    task automatic test_zero_stuff();
        logic [7:0] exp_zs [4] = '{8'h05, 8'h00, 8'h00, 8'h00};
        do_reset();
        write(8'h05);
        tests++; if (zs_lvl !== 2'd1) begin fails++; $display("FAIL zs_level got %0d want 1", zs_lvl); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (zs_str !== 1'b1 || hd_str !== 1'b1) begin fails++; $display("FAIL zs_strobe tick %0d got %b/%b want 1", i, zs_str, hd_str); end
            tests++; if (zs_data !== exp_zs[i] || hd_data !== 8'h05) begin fails++; $display("FAIL zs_data tick %0d got %h/%h want %h/05", i, zs_data, hd_data, exp_zs[i]); end
            cyc();
            tests++; if (zs_str !== 1'b0 || zs_data !== exp_zs[i]) begin fails++; $display("FAIL zs_idle tick %0d got str %b data %h want 0 %h", i, zs_str, zs_data, exp_zs[i]); end
        end
        tests++; if (zs_udf !== 1'b0 || hd_udf !== 1'b0) begin fails++; $display("FAIL zs_underflow got %b/%b want 0", zs_udf, hd_udf); end
    endtask

    task automatic test_hold();
        logic [7:0] exp_hd [8] = '{8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'h10, 8'h10, 8'h10, 8'h10};
        logic [7:0] exp_zs [8] = '{8'hFD, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
        do_reset();
        write(8'hFD);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) write(8'h10);
            tick();
            tests++; if (hd_data !== exp_hd[i] || zs_data !== exp_zs[i]) begin fails++; $display("FAIL hold_data tick %0d got %h/%h want %h/%h", i, hd_data, zs_data, exp_hd[i], exp_zs[i]); end
            cyc();
        end
        tests++; if (hd_udf !== 1'b0 || hd_lvl !== 2'd0) begin fails++; $display("FAIL hold_end got udf %b lvl %0d want 0 0", hd_udf, hd_lvl); end
    endtask

    task automatic test_underflow();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (zs_str !== 1'b1 || zs_data !== 8'h00 || hd_data !== 8'h00) begin fails++; $display("FAIL udf_tick %0d got str %b data %h/%h want 1 00/00", i, zs_str, zs_data, hd_data); end
        end
        tests++; if (zs_udf !== 1'b1 || hd_udf !== 1'b1) begin fails++; $display("FAIL udf_flag got %b/%b want 1", zs_udf, hd_udf); end
        write(8'h22);
        tick();
        tests++; if (zs_data !== 8'h22 || hd_data !== 8'h22) begin fails++; $display("FAIL udf_recover got %h/%h want 22/22", zs_data, hd_data); end
        tests++; if (zs_udf !== 1'b1) begin fails++; $display("FAIL udf_sticky got %b want 1", zs_udf); end
    endtask

    task automatic test_no_bypass();
        do_reset();
        inp_samp_data = 8'h33; inp_samp_str = 1'b1; out_tick = 1'b1;
        cyc();
        inp_samp_str = 1'b0; out_tick = 1'b0;
        tests++; if (zs_data !== 8'h00 || zs_udf !== 1'b1 || zs_lvl !== 2'd1) begin fails++; $display("FAIL bypass got data %h udf %b lvl %0d want 00 1 1", zs_data, zs_udf, zs_lvl); end
        tick();
        tests++; if (zs_data !== 8'h33 || hd_data !== 8'h33) begin fails++; $display("FAIL bypass_next got %h/%h want 33/33", zs_data, hd_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_hd [8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02};
        logic [7:0] exp_zs [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        do_reset();
        write(8'h01);
        write(8'h02);
        tests++; if (zs_ovf !== 1'b0) begin fails++; $display("FAIL ovf_early got %b want 0", zs_ovf); end
        write(8'h03);
        tests++; if (zs_lvl !== 2'd2 || zs_ovf !== 1'b1 || hd_ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got lvl %0d ovf %b/%b want 2 1/1", zs_lvl, zs_ovf, hd_ovf); end
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++; if (zs_data !== exp_zs[i] || hd_data !== exp_hd[i]) begin fails++; $display("FAIL ovf_data tick %0d got %h/%h want %h/%h", i, zs_data, hd_data, exp_zs[i], exp_hd[i]); end
        end
        tests++; if (zs_lvl !== 2'd0 || zs_udf !== 1'b0 || zs_ovf !== 1'b1) begin fails++; $display("FAIL ovf_end got lvl %0d udf %b ovf %b want 0 0 1", zs_lvl, zs_udf, zs_ovf); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write(8'hA1);
        write(8'hA2);
        inp_samp_data = 8'hA3; inp_samp_str = 1'b1; out_tick = 1'b1;
        cyc();
        inp_samp_str = 1'b0; out_tick = 1'b0;
        tests++; if (zs_data !== 8'hA1 || zs_lvl !== 2'd2 || zs_ovf !== 1'b0) begin fails++; $display("FAIL full_pop got data %h lvl %0d ovf %b want A1 2 0", zs_data, zs_lvl, zs_ovf); end
        for (int i = 0; i < 3; i++) tick();
        tick();
        tests++; if (zs_data !== 8'hA2 || zs_lvl !== 2'd1) begin fails++; $display("FAIL wrap_a2 got data %h lvl %0d want A2 1", zs_data, zs_lvl); end
        for (int i = 0; i < 3; i++) tick();
        tick();
        tests++; if (hd_data !== 8'hA3 || hd_lvl !== 2'd0 || hd_udf !== 1'b0) begin fails++; $display("FAIL wrap_a3 got data %h lvl %0d udf %b want A3 0 0", hd_data, hd_lvl, hd_udf); end
    endtask

    task automatic test_clear();
        do_reset();
        write(8'h7F);
        write(8'h11);
        write(8'h12);
        tick();
        tick();
        tests++; if (hd_data !== 8'h7F || hd_ovf !== 1'b1 || hd_lvl !== 2'd1) begin fails++; $display("FAIL pre_clear got data %h ovf %b lvl %0d want 7F 1 1", hd_data, hd_ovf, hd_lvl); end
        clear = 1'b1; out_tick = 1'b1; inp_samp_str = 1'b1; inp_samp_data = 8'h55;
        cyc();
        clear = 1'b0; out_tick = 1'b0; inp_samp_str = 1'b0;
        tests++; if (hd_data !== 8'h00 || hd_str !== 1'b0 || hd_ovf !== 1'b0 || hd_udf !== 1'b0) begin fails++; $display("FAIL clear_out got data %h str %b ovf %b udf %b want 00 0 0 0", hd_data, hd_str, hd_ovf, hd_udf); end
        tests++; if (hd_lvl !== 2'd0 || zs_lvl !== 2'd0) begin fails++; $display("FAIL clear_level got %0d/%0d want 0/0", hd_lvl, zs_lvl); end
        tick();
        tests++; if (hd_data !== 8'h00 || hd_str !== 1'b1 || hd_udf !== 1'b1) begin fails++; $display("FAIL post_clear got data %h str %b udf %b want 00 1 1", hd_data, hd_str, hd_udf); end
    endtask

    initial begin
        test_reset();
        test_zero_stuff();
        test_hold();
        test_underflow();
        test_no_bypass();
        test_overflow();
        test_back_to_back();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
